// File: rtl/rice_partition_scheduler.sv
// rice_partition_scheduler: splits a frame's residuals into Rice partitions, ping-pongs
// them between two parameter optimizers and hands the best parameters out in order.
// Ports:
//   iClock, iReset_n          clock, asynchronous active-low reset
//   iEnable                   global advance; low freezes all state and pulses
//   iFrameStart, iM           frame start (IDLE only) and predictor order
//   iValid                    residual sample present
//   oOptValid[1:0]            sample strobe routed to optimizer A (0) or B (1)
//   oOptReset[1:0]            one-cycle optimizer reset pulses
//   oOptNSamples              sample target of the current partition
//   iOptDone[1:0], iOptBest   optimizer completion and {B, A} best parameters
//   oParamValid, oRiceParam,  in-order parameter handoff with partition index,
//   oParamPart, iParamAck     taken on iParamAck
//   oFlush, oFrameDone        end-of-frame pulses
//   oBusy, oError[1:0]        activity and sticky {start-while-busy, overrun} flags
module rice_partition_scheduler #(
    parameter int PARTITION_SIZE  = 1024,
    parameter int PARTS_PER_FRAME = 4,
    parameter int CNT_W           = 11
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iEnable,
    input  logic             iFrameStart,
    input  logic [3:0]       iM,
    input  logic             iValid,
    output logic [1:0]       oOptValid,
    output logic [1:0]       oOptReset,
    output logic [CNT_W-1:0] oOptNSamples,
    input  logic [1:0]       iOptDone,
    input  logic [7:0]       iOptBest,
    output logic             oParamValid,
    output logic [3:0]       oRiceParam,
    output logic [2:0]       oParamPart,
    input  logic             iParamAck,
    output logic             oFlush,
    output logic             oFrameDone,
    output logic             oBusy,
    output logic [1:0]       oError
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    localparam logic [2:0]       LAST_PART = 3'(PARTS_PER_FRAME - 1);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(PARTITION_SIZE);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, target;
    logic [2:0]       part, param_part;
    logic             sel, head;
    logic [1:0]       pending, res_valid, opt_reset, err;
    logic [3:0]       res_a, res_b;
    logic             start, take, wrap, flush, acc;
    logic [1:0]       done_hit, cap, ack_mask, sel_mask;

    always_comb begin
        state_nxt = state;
        start     = iEnable && iFrameStart && state == IDLE;
        take      = iEnable && iValid && state == FILL;
        wrap      = take && cnt == target - CNT_W'(1);
        flush     = iEnable && state == DRAIN && pending == 2'b00 && res_valid == 2'b00;
        case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (wrap && part == LAST_PART) state_nxt = DRAIN;
            DRAIN:   if (flush) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_mask     = sel ? 2'b10 : 2'b01;
    assign oOptValid    = take ? sel_mask : 2'b00;
    assign oParamValid  = head ? res_valid[1] : res_valid[0];
    assign oRiceParam   = head ? res_b : res_a;
    assign acc          = iEnable && iParamAck && oParamValid;
    assign ack_mask     = acc ? (head ? 2'b10 : 2'b01) : 2'b00;
    // A done with an unacked result still parked on that side is dropped (overrun).
    assign done_hit     = iEnable ? iOptDone & pending : 2'b00;
    assign cap          = done_hit & ~res_valid;
    assign oOptReset    = opt_reset;
    assign oOptNSamples = target;
    assign oParamPart   = param_part;
    assign oFlush       = flush;
    assign oFrameDone   = flush;
    assign oBusy        = state != IDLE;
    assign oError       = err;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) state <= IDLE;
        else if (iEnable) state <= state_nxt;
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            cnt        <= '0;
            target     <= '0;
            part       <= '0;
            param_part <= '0;
            sel        <= 1'b0;
            head       <= 1'b0;
            pending    <= '0;
            res_valid  <= '0;
            opt_reset  <= '0;
            err        <= '0;
            res_a      <= '0;
            res_b      <= '0;
        end else begin
            opt_reset <= iEnable ? (start ? 2'b11 : done_hit) : 2'b00;
            if (iEnable) begin
                // New-partition pending wins over a same-cycle completion clear.
                pending   <= (pending & ~done_hit) | (wrap ? sel_mask : 2'b00);
                res_valid <= (res_valid & ~ack_mask) | cap;
                if (cap[0]) res_a <= iOptBest[3:0];
                if (cap[1]) res_b <= iOptBest[7:4];
                if (iFrameStart && state != IDLE) err[1] <= 1'b1;
                if ((take && (pending[sel] || res_valid[sel])) || (iOptDone & res_valid) != 2'b00)
                    err[0] <= 1'b1;
                if (start) begin
                    target     <= FULL - CNT_W'(iM);
                    cnt        <= '0;
                    part       <= '0;
                    sel        <= 1'b0;
                    head       <= 1'b0;
                    param_part <= '0;
                end
                if (take) begin
                    cnt <= wrap ? '0 : cnt + CNT_W'(1);
                    if (wrap) begin
                        sel    <= ~sel;
                        target <= FULL;
                        part   <= part + 3'd1;
                    end
                end
                if (acc) begin
                    head       <= ~head;
                    param_part <= param_part + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rice_partition_scheduler.sv
// tb_rice_partition_scheduler: directed bench with an in-order parameter scoreboard.
module tb_rice_partition_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        fs = 1'b0;
    logic [3:0]  m = '0;
    logic        vld = 1'b0;
    logic [1:0]  done = '0;
    logic [7:0]  best = '0;
    logic        ack = 1'b0;
    logic [1:0]  opt_valid, opt_reset, err;
    logic [10:0] nsamples;
    logic        param_valid, flush, frame_done, busy;
    logic [3:0]  rice;
    logic [2:0]  ppart;

    int vectors = 0;
    int miscompares = 0;
    logic [6:0] sb[$];

    rice_partition_scheduler dut (
        .iClock(clk), .iReset_n(rst_n), .iEnable(en), .iFrameStart(fs), .iM(m),
        .iValid(vld), .oOptValid(opt_valid), .oOptReset(opt_reset), .oOptNSamples(nsamples),
        .iOptDone(done), .iOptBest(best), .oParamValid(param_valid), .oRiceParam(rice),
        .oParamPart(ppart), .iParamAck(ack), .oFlush(flush), .oFrameDone(frame_done),
        .oBusy(busy), .oError(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input string tag, input int n, input logic [1:0] exp);
        int good = 0;
        for (int i = 0; i < n; i++) begin
            vld = 1'b1;
            #1;
            if (opt_valid === exp) good++;
            @(posedge clk);
            #1;
        end
        vld = 1'b0;
        chk(tag, good, n);
    endtask

    task automatic pulse_done(input logic [1:0] d, input logic [7:0] b);
        done = d;
        best = b;
        tick();
        done = 2'b00;
    endtask

    task automatic ack_pop(input string tag);
        logic [6:0] e;
        chk({tag, "_sb"}, sb.size() != 0, 1);
        e = (sb.size() != 0) ? sb.pop_front() : 7'h7f;
        chk({tag, "_valid"}, param_valid, 1);
        chk({tag, "_rice"}, rice, e[3:0]);
        chk({tag, "_part"}, ppart, e[6:4]);
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_optreset", opt_reset, 0);
        chk("rst_nsamples", nsamples, 0);
        chk("rst_err", err, 0);
        chk("rst_pvalid", param_valid, 0);
        rst_n = 1'b1;
        tick();

        // frame 1: m = 2
        fs = 1'b1; m = 4'd2;
        tick();
        fs = 1'b0;
        chk("f1_optreset", opt_reset, 2'b11);
        chk("f1_nsamples0", nsamples, 1022);
        chk("f1_busy", busy, 1);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        chk("f1_optreset_once", opt_reset, 2'b00);
        chk("f1_err_start_busy", err, 2'b10);
        feed("f1_p0_route", 1022, 2'b01);
        chk("f1_nsamples1", nsamples, 1024);
        feed("f1_p1_route", 1024, 2'b10);
        pulse_done(2'b01, 8'h05);
        sb.push_back({3'd0, 4'd5});
        chk("f1_rstA", opt_reset, 2'b01);
        ack_pop("f1_a");
        chk("f1_no_valid_B", param_valid, 0);
        pulse_done(2'b10, 8'h90);
        sb.push_back({3'd1, 4'd9});
        chk("f1_rstB", opt_reset, 2'b10);
        ack_pop("f1_b");
        feed("f1_p2_route", 1024, 2'b01);
        feed("f1_p3_route", 1024, 2'b10);
        vld = 1'b1;
        #1;
        chk("f1_drain_novalid", opt_valid, 0);
        chk("f1_drain_busy", busy, 1);
        vld = 1'b0;
        pulse_done(2'b11, 8'h73);
        sb.push_back({3'd2, 4'd3});
        sb.push_back({3'd3, 4'd7});
        chk("f1_rstAB", opt_reset, 2'b11);
        ack_pop("f1_c");
        chk("f1_no_flush_early", flush, 0);
        ack_pop("f1_d");
        chk("f1_flush", flush, 1);
        chk("f1_frame_done", frame_done, 1);
        tick();
        chk("f1_flush_once", flush, 0);
        chk("f1_idle", busy, 0);
        chk("f1_err_end", err, 2'b10);

        // frame 2: m = 0, held ack and overrun
        fs = 1'b1; m = 4'd0;
        tick();
        fs = 1'b0;
        chk("f2_nsamples0", nsamples, 1024);
        chk("f2_ppart", ppart, 0);
        feed("f2_p0_route", 1024, 2'b01);
        feed("f2_p1_route", 1024, 2'b10);
        pulse_done(2'b01, 8'h04);
        sb.push_back({3'd0, 4'd4});
        feed("f2_p2_route", 1024, 2'b01);
        chk("f2_overrun", err, 2'b11);
        pulse_done(2'b10, 8'h60);
        sb.push_back({3'd1, 4'd6});
        chk("f2_head_waits", rice, 4);
        ack_pop("f2_a");
        ack_pop("f2_b");
        chk("f2_head_empty", param_valid, 0);
        pulse_done(2'b01, 8'h02);
        sb.push_back({3'd2, 4'd2});
        chk("f2_a2_valid", param_valid, 1);
        feed("f2_p3_route", 10, 2'b10);
        vld = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_optvalid", opt_valid, 0);
        chk("mid_rst_pvalid", param_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_nsamples", nsamples, 0);
        chk("mid_rst_flush", flush, 0);
        vld = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // frame 3: m = 5 after reset
        fs = 1'b1; m = 4'd5;
        tick();
        fs = 1'b0;
        chk("f3_nsamples0", nsamples, 1019);
        chk("f3_ppart", ppart, 0);
        feed("f3_p0_route", 1019, 2'b01);
        feed("f3_p1_route", 3, 2'b10);
        pulse_done(2'b01, 8'h01);
        sb.push_back({3'd0, 4'd1});
        ack_pop("f3_a");
        chk("f3_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
